// File: rtl/nios_multi_timer.sv
// nios_multi_timer: multi-channel Avalon-MM interval timer (Nios II s1 slave).
//
// NUM_CH independent down-counters. Each channel has a prescaler, one-shot or
// continuous mode, snapshot capture and a maskable timeout interrupt.
//
// Optional feature macro: NIOS_TIMER_PWM_EN
//   When it is defined, the per-channel COMPARE register and the pwm_out port exist.
//   When it is undefined, the COMPARE address reads 0 and writes to it are ignored.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     word address {ch, reg[2:0]}
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   32-bit write data
//   readdata    registered read data, 1-cycle latency
//   irq         OR over channels of (TO & ITO)
//   irq_vec     per-channel TO & ITO
//   pwm_out     per-channel PWM (NIOS_TIMER_PWM_EN only)
module nios_multi_timer #(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned CNT_W        = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h005F5E0F,
  localparam int unsigned ADDR_W      = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
`ifdef NIOS_TIMER_PWM_EN
  output logic [NUM_CH-1:0] pwm_out,
`endif
  output logic [NUM_CH-1:0] irq_vec
);

  localparam logic [CNT_W-1:0] RstPeriod = RESET_PERIOD[CNT_W-1:0];

  // Per-channel state
  logic [NUM_CH-1:0] r_run, r_to, r_ito, r_cont;
  logic [7:0]        r_presc  [NUM_CH];
  logic [7:0]        r_pcnt   [NUM_CH];
  logic [CNT_W-1:0]  r_period [NUM_CH];
  logic [CNT_W-1:0]  r_cnt    [NUM_CH];
  logic [CNT_W-1:0]  r_snap   [NUM_CH];
  logic [31:0]       r_rdata;

  // Next-state values
  logic [NUM_CH-1:0] w_run_d, w_to_d, w_ito_d, w_cont_d;
  logic [7:0]        w_presc_d  [NUM_CH];
  logic [7:0]        w_pcnt_d   [NUM_CH];
  logic [CNT_W-1:0]  w_period_d [NUM_CH];
  logic [CNT_W-1:0]  w_cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  w_snap_d   [NUM_CH];
  logic [31:0]       w_rdata;

  logic [NUM_CH-1:0] w_tick, w_tmo, w_sel;
  logic              w_wr, w_ch_ok;
  logic [ADDR_W-1:0] w_ch;
  logic [2:0]        w_reg;

`ifdef NIOS_TIMER_PWM_EN
  logic [CNT_W-1:0]  r_cmp   [NUM_CH];
  logic [CNT_W-1:0]  w_cmp_d [NUM_CH];
  logic [NUM_CH-1:0] r_pwm;
  assign pwm_out = r_pwm;
`endif

  assign w_wr    = chipselect & ~write_n;
  assign w_ch    = address >> 3;
  assign w_reg   = address[2:0];
  assign w_ch_ok = (32'(w_ch) < NUM_CH);

  assign irq_vec  = r_to & r_ito;
  assign irq      = |irq_vec;
  assign readdata = r_rdata;

  always_comb begin
    w_run_d  = r_run;
    w_to_d   = r_to;
    w_ito_d  = r_ito;
    w_cont_d = r_cont;
    w_rdata  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_sel[i]      = w_wr & w_ch_ok & (32'(w_ch) == i);
      w_presc_d[i]  = r_presc[i];
      w_period_d[i] = r_period[i];
      w_cnt_d[i]    = r_cnt[i];
      w_snap_d[i]   = r_snap[i];
`ifdef NIOS_TIMER_PWM_EN
      w_cmp_d[i]    = r_cmp[i];
`endif
      w_tick[i] = r_run[i] & (r_pcnt[i] == r_presc[i]);
      w_tmo[i]  = w_tick[i] & ((r_cnt[i] == CNT_W'(1)) |
                               ((r_cnt[i] == '0) & (r_period[i] == '0)));

      // Prescale count runs only while RUN=1 and is otherwise held at 0.
      if (r_run[i]) w_pcnt_d[i] = w_tick[i] ? 8'd0 : r_pcnt[i] + 8'd1;
      else          w_pcnt_d[i] = 8'd0;

      // A counter sitting at 0 reloads instead of decrementing.
      if (w_tick[i]) begin
        w_cnt_d[i] = (r_cnt[i] == '0) ? r_period[i] : r_cnt[i] - CNT_W'(1);
      end
      if (w_tmo[i]) begin
        w_to_d[i] = 1'b1;
        if (!r_cont[i]) w_run_d[i] = 1'b0;
      end

      // Bus writes override the counting path; a coincident timeout keeps TO set.
      if (w_sel[i]) begin
        case (w_reg)
          3'd0: w_to_d[i] = w_tmo[i];
          3'd1: begin
            w_ito_d[i]   = writedata[0];
            w_cont_d[i]  = writedata[1];
            w_presc_d[i] = writedata[11:4];
            if (writedata[2])      w_run_d[i] = 1'b1;
            else if (writedata[3]) w_run_d[i] = 1'b0;
          end
          3'd2: begin
            w_period_d[i] = writedata[CNT_W-1:0];
            w_cnt_d[i]    = writedata[CNT_W-1:0];
            w_run_d[i]    = 1'b0;
            w_pcnt_d[i]   = 8'd0;
          end
          3'd3: w_snap_d[i] = r_cnt[i];
`ifdef NIOS_TIMER_PWM_EN
          3'd4: w_cmp_d[i] = writedata[CNT_W-1:0];
`endif
          default: ;
        endcase
      end

      if (w_ch_ok && (32'(w_ch) == i)) begin
        case (w_reg)
          3'd0: w_rdata = {30'd0, r_run[i], r_to[i]};
          3'd1: w_rdata = {20'd0, r_presc[i], 2'b00, r_cont[i], r_ito[i]};
          3'd2: w_rdata = 32'(r_period[i]);
          3'd3: w_rdata = 32'(r_snap[i]);
`ifdef NIOS_TIMER_PWM_EN
          3'd4: w_rdata = 32'(r_cmp[i]);
`endif
          default: w_rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run   <= '0;
      r_to    <= '0;
      r_ito   <= '0;
      r_cont  <= '0;
      r_rdata <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_presc[i]  <= '0;
        r_pcnt[i]   <= '0;
        r_period[i] <= RstPeriod;
        r_cnt[i]    <= RstPeriod;
        r_snap[i]   <= '0;
`ifdef NIOS_TIMER_PWM_EN
        r_cmp[i]    <= '0;
`endif
      end
`ifdef NIOS_TIMER_PWM_EN
      r_pwm <= '0;
`endif
    end else begin
      r_run   <= w_run_d;
      r_to    <= w_to_d;
      r_ito   <= w_ito_d;
      r_cont  <= w_cont_d;
      r_rdata <= w_rdata;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_presc[i]  <= w_presc_d[i];
        r_pcnt[i]   <= w_pcnt_d[i];
        r_period[i] <= w_period_d[i];
        r_cnt[i]    <= w_cnt_d[i];
        r_snap[i]   <= w_snap_d[i];
`ifdef NIOS_TIMER_PWM_EN
        r_cmp[i]    <= w_cmp_d[i];
        r_pwm[i]    <= r_run[i] & (r_cnt[i] < r_cmp[i]);
`endif
      end
    end
  end

endmodule
